// File: rtl/tc_ps_gp_pkg.sv
// -----------------------------------------------------------------------------
// tc_ps_gp_pkg
// Shared definitions for the PS GP0 register-bus blocks.
//   - gp_wr_state_e : write-slave FSM state encoding (IDLE/SETUP/STROBE/RESP)
//   - RESP_*        : AXI write-response codes
//   - WTH_ADDR/ADDL : register-bus address width and the split point between
//                     the group index (addr[WTH_ADDR-1:WTH_ADDL]) and the
//                     register offset inside a group
//   - GRP_*         : group indices decoded from addr[WTH_ADDR-1:WTH_ADDL]
// -----------------------------------------------------------------------------
package tc_ps_gp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_RESP   = 2'd3
   } gp_wr_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int WTH_ADDR = 32;
   localparam int WTH_ADDL = 10;

   localparam int GRP_GLOBAL  = 0;
   localparam int GRP_CAPTURE = 1;
   localparam int GRP_LASER   = 2;
   localparam int GRP_BUS     = 3;
   localparam int GRP_OTHER   = 4;

endpackage

// File: rtl/tc_ps_gp_axil_wr_if.sv
// -----------------------------------------------------------------------------
// tc_ps_gp_axil_wr_if
// AXI4-Lite write channels (AW, W, B) between the PS GP0 master and the
// register-bus write slave.
//   master modport : drives AW/W payload + valids and bready
//   slave  modport : drives awready, wready, bvalid, bresp
// Parameter AXI_AW : byte-address width of s_awaddr.
// -----------------------------------------------------------------------------
interface tc_ps_gp_axil_wr_if #(
   parameter int AXI_AW = 32
) ();

   logic [AXI_AW-1:0] s_awaddr;
   logic              s_awvalid;
   logic              s_awready;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic              s_wvalid;
   logic              s_wready;
   logic [1:0]        s_bresp;
   logic              s_bvalid;
   logic              s_bready;

   modport master (
      output s_awaddr, s_awvalid,
      input  s_awready,
      output s_wdata, s_wstrb, s_wvalid,
      input  s_wready,
      input  s_bresp, s_bvalid,
      output s_bready
   );

   modport slave (
      input  s_awaddr, s_awvalid,
      output s_awready,
      input  s_wdata, s_wstrb, s_wvalid,
      output s_wready,
      output s_bresp, s_bvalid,
      input  s_bready
   );

endinterface

// File: rtl/tc_ps_gp_axil_wr.sv
// -----------------------------------------------------------------------------
// tc_ps_gp_axil_wr
// AXI4-Lite write slave terminating PS GP0 writes and turning each accepted
// write into an addr/data/wren triple for the GP0 write-data decoder.
// One write in flight; addr/data are presented one full cycle (SETUP) before
// the single-cycle wren pulse (STROBE) because the decoder registers its group
// select from addr before it qualifies wren.
//
// Ports
//   clk   : clock shared with the decoder
//   rst   : asynchronous active-high reset (aborts any write in flight)
//   axil  : AXI4-Lite AW/W/B channels (slave modport); s_wstrb is ignored
//   addr  : word address (byte address >> ADDR_SHIFT), held between writes
//   data  : write data, held between writes
//   wren  : one-cycle write strobe
//
// Parameters
//   AXI_AW     : AXI byte-address width
//   ADDR_SHIFT : byte-to-word address shift
//   ADDR_H_MAX : highest valid group index (addr[31:10]); only used when
//                TC_GP_WR_ADDR_CHECK_EN is defined
//
// Build option
//   TC_GP_WR_ADDR_CHECK_EN : when defined, a write whose group index exceeds
//                            ADDR_H_MAX is not strobed and answers SLVERR,
//                            with unchanged timing.
// -----------------------------------------------------------------------------
module tc_ps_gp_axil_wr
   import tc_ps_gp_pkg::*;
#(
   parameter int AXI_AW     = 32,
   parameter int ADDR_SHIFT = 2,
   parameter int ADDR_H_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   tc_ps_gp_axil_wr_if.slave    axil,
   output logic [31:0]          addr,
   output logic [31:0]          data,
   output logic                 wren
);

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_SETUP  = 2'(ST_SETUP);
   localparam logic [1:0] S_STROBE = 2'(ST_STROBE);
   localparam logic [1:0] S_RESP   = 2'(ST_RESP);

   localparam int GRP_W = WTH_ADDR - WTH_ADDL;

   logic [1:0]        state_q, state_d;
   logic              aw_got_q, aw_got_d;
   logic              w_got_q, w_got_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic              wren_q, wren_d;

   logic              aw_fire;
   logic              w_fire;
   logic [AXI_AW-1:0] awaddr_sh;
   logic              wr_err;
   logic              unused_wstrb;

   // Full-word writes only: strobes are accepted but carry no meaning here.
   assign unused_wstrb = ^axil.s_wstrb;

   // Readies are registered and only ever high in IDLE, so a fire can only
   // happen while idle.
   assign aw_fire   = axil.s_awvalid & awready_q;
   assign w_fire    = axil.s_wvalid  & wready_q;
   // Unaligned low bits fall off the shift.
   assign awaddr_sh = axil.s_awaddr >> ADDR_SHIFT;

`ifdef TC_GP_WR_ADDR_CHECK_EN
   localparam logic [GRP_W-1:0] GRP_MAX = GRP_W'(ADDR_H_MAX);
   // Evaluated in SETUP, where addr_q already holds the accepted address.
   assign wr_err = (addr_q[WTH_ADDR-1:WTH_ADDL] > GRP_MAX);
`else
   localparam int unused_addr_h_max = ADDR_H_MAX;
   localparam int unused_grp_w      = GRP_W;
   assign wr_err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wren_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (aw_fire) begin
               addr_d   = 32'(awaddr_sh);
               aw_got_d = 1'b1;
            end
            if (w_fire) begin
               data_d  = axil.s_wdata;
               w_got_d = 1'b1;
            end
            // Covers same-cycle AW+W as well as either order with any gap.
            if (aw_got_d && w_got_d) begin
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            // The response is raised together with the strobe so the master
            // sees bvalid in the wren cycle.
            state_d  = S_STROBE;
            wren_d   = ~wr_err;
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
         end

         S_STROBE: begin
            // A bready already high in the strobe cycle completes the B
            // handshake here; RESP then only returns to IDLE.
            state_d = S_RESP;
            if (axil.s_bready) begin
               bvalid_d = 1'b0;
            end
         end

         S_RESP: begin
            if (!bvalid_q || axil.s_bready) begin
               bvalid_d = 1'b0;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               state_d  = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered readies: they follow the state and capture flags of the
      // next cycle, so they drop right after a handshake and come back the
      // cycle after the FSM re-enters IDLE.
      awready_d = (state_d == S_IDLE) & ~aw_got_d;
      wready_d  = (state_d == S_IDLE) & ~w_got_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         addr_q    <= '0;
         data_q    <= '0;
         wren_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         wren_q    <= wren_d;
      end
   end

   assign axil.s_awready = awready_q;
   assign axil.s_wready  = wready_q;
   assign axil.s_bvalid  = bvalid_q;
   assign axil.s_bresp   = bresp_q;
   assign addr           = addr_q;
   assign data           = data_q;
   assign wren           = wren_q;

endmodule

// File: tb/tb_tc_ps_gp_axil_wr.sv
// -----------------------------------------------------------------------------
// tb_tc_ps_gp_axil_wr
// Self-checking bench for tc_ps_gp_axil_wr. A transaction-level reference
// model (negedge monitor) tracks which AW/W beats have been accepted, when
// each write becomes complete, and derives the expected readies, wren, bvalid,
// bresp, addr and data for every cycle. Directed scenarios plus a randomized
// run drive the bus. Honors TC_GP_WR_ADDR_CHECK_EN for the expected responses.
// -----------------------------------------------------------------------------
module tb_tc_ps_gp_axil_wr;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] data;
   logic        wren;

   tc_ps_gp_axil_wr_if #(.AXI_AW(32)) bus ();

   tc_ps_gp_axil_wr #(
      .AXI_AW     (32),
      .ADDR_SHIFT (2),
      .ADDR_H_MAX (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .axil (bus),
      .addr (addr),
      .data (data),
      .wren (wren)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   int          cyc       = 0;
   bit          settle    = 1'b1;
   bit          aw_t      = 1'b0;
   bit          w_t       = 1'b0;
   bit          busy      = 1'b0;
   bit          exp_wr    = 1'b0;
   logic [1:0]  exp_resp  = 2'b00;
   int          hs_cyc    = 0;
   int          idle_from = 0;
   logic [31:0] addr_m    = '0;
   logic [31:0] data_m    = '0;
   int          wren_cnt  = 0;

   function automatic bit grp_bad(input logic [31:0] wa);
`ifdef TC_GP_WR_ADDR_CHECK_EN
      return (wa >> 10) > 32'd4;
`else
      return 1'b0 & wa[0];
`endif
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         aw_t      = 1'b0;
         w_t       = 1'b0;
         busy      = 1'b0;
         addr_m    = '0;
         data_m    = '0;
         idle_from = 0;
         settle    = 1'b1;
      end else begin
         cyc++;
         if (!settle) begin
            check_eq("awready", 32'(bus.s_awready), 32'(!aw_t && !busy && cyc >= idle_from));
            check_eq("wready",  32'(bus.s_wready),  32'(!w_t && !busy && cyc >= idle_from));
            check_eq("wren",    32'(wren),   32'(busy && exp_wr && cyc == hs_cyc + 2));
            check_eq("bvalid",  32'(bus.s_bvalid), 32'(busy && cyc >= hs_cyc + 2));
            check_eq("addr", addr, addr_m);
            check_eq("data", data, data_m);
            if (bus.s_bvalid) check_eq("bresp", 32'(bus.s_bresp), 32'(exp_resp));
         end
         settle = 1'b0;
         if (wren) wren_cnt++;
         // advance the model with the handshakes completing at the next edge
         if (busy && bus.s_bvalid && bus.s_bready) begin
            busy      = 1'b0;
            aw_t      = 1'b0;
            w_t       = 1'b0;
            idle_from = (cyc + 1 > hs_cyc + 4) ? cyc + 1 : hs_cyc + 4;
         end
         if (bus.s_awvalid && bus.s_awready) begin
            aw_t   = 1'b1;
            addr_m = bus.s_awaddr >> 2;
         end
         if (bus.s_wvalid && bus.s_wready) begin
            w_t    = 1'b1;
            data_m = bus.s_wdata;
         end
         if (aw_t && w_t && !busy) begin
            busy     = 1'b1;
            hs_cyc   = cyc;
            exp_wr   = !grp_bad(addr_m);
            exp_resp = grp_bad(addr_m) ? 2'b10 : 2'b00;
         end
      end
   end

   // ---------------- bready driver ----------------
   int bmode = 0;  // 0: always 1, 1: random, 2: held low
   initial begin
      bus.s_bready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bmode)
            0:       bus.s_bready = 1'b1;
            1:       bus.s_bready = 1'($urandom_range(0, 1));
            default: bus.s_bready = 1'b0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int da, input int dw);
      bit ad = 1'b0;
      bit wd = 1'b0;
      int n  = 0;
      while (!(ad && wd) && n < 200) begin
         bus.s_awvalid = !ad && (n >= da);
         bus.s_awaddr  = a;
         bus.s_wvalid  = !wd && (n >= dw);
         bus.s_wdata   = d;
         bus.s_wstrb   = 4'($urandom);
         @(negedge clk);
         if (bus.s_awvalid && bus.s_awready) ad = 1'b1;
         if (bus.s_wvalid && bus.s_wready)   wd = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      check_eq("write_accepted", 32'(ad && wd), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || cyc < idle_from) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("idle_reached", 32'(busy), 32'd0);
   endtask

   int c0;
   int first_hs;

   initial begin
      rst           = 1'b1;
      bus.s_awvalid = 1'b0;
      bus.s_awaddr  = '0;
      bus.s_wvalid  = 1'b0;
      bus.s_wdata   = '0;
      bus.s_wstrb   = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_awready", 32'(bus.s_awready), 32'd0);
      check_eq("rst_wready",  32'(bus.s_wready),  32'd0);
      check_eq("rst_bvalid",  32'(bus.s_bvalid),  32'd0);
      check_eq("rst_bresp",   32'(bus.s_bresp),   32'd0);
      check_eq("rst_addr", addr, 32'd0);
      check_eq("rst_data", data, 32'd0);
      check_eq("rst_wren", 32'(wren), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rel_awready", 32'(bus.s_awready), 32'd1);
      check_eq("rel_wready",  32'(bus.s_wready),  32'd1);

      // same-cycle AW+W; do_write returns in the SETUP cycle
      do_write(32'h0000_1008, 32'h0000_0005, 0, 0);
      check_eq("sc_setup_wren", 32'(wren), 32'd0);
      check_eq("sc_setup_addr", addr, 32'h0000_0402);
      check_eq("sc_setup_data", data, 32'h0000_0005);
      @(posedge clk);
      #1;
      check_eq("sc_wren",   32'(wren), 32'd1);
      check_eq("sc_bvalid", 32'(bus.s_bvalid), 32'd1);
      check_eq("sc_bresp",  32'(bus.s_bresp), 32'd0);
      check_eq("sc_addr", addr, 32'h0000_0402);
      @(posedge clk);
      #1;
      check_eq("sc_wren_single", 32'(wren), 32'd0);
      wait_idle();

      // W first, AW three cycles later
      c0 = wren_cnt;
      do_write(32'h0000_3018, 32'hDEAD_BEEF, 3, 0);
      @(posedge clk);
      #1;
      check_eq("wf_wren", 32'(wren), 32'd1);
      check_eq("wf_addr", addr, 32'h0000_0C06);
      check_eq("wf_data", data, 32'hDEAD_BEEF);
      wait_idle();
      check_eq("wf_count", 32'(wren_cnt - c0), 32'd1);

      // B backpressure with a second AW/W waiting
      bmode = 2;
      repeat (2) @(posedge clk);
      #1;
      c0 = wren_cnt;
      do_write(32'h0000_2000, 32'h0000_0011, 0, 0);
      bus.s_awvalid = 1'b1;
      bus.s_awaddr  = 32'h0000_2004;
      bus.s_wvalid  = 1'b1;
      bus.s_wdata   = 32'h0000_0022;
      repeat (10) @(posedge clk);
      #1;
      check_eq("bp_bvalid",  32'(bus.s_bvalid),  32'd1);
      check_eq("bp_awready", 32'(bus.s_awready), 32'd0);
      check_eq("bp_wready",  32'(bus.s_wready),  32'd0);
      check_eq("bp_addr_held", addr, 32'h0000_0800);
      bmode = 0;
      do_write(32'h0000_2004, 32'h0000_0022, 0, 0);
      wait_idle();
      check_eq("bp_count", 32'(wren_cnt - c0), 32'd2);
      check_eq("bp_addr2", addr, 32'h0000_0801);

      // reset asserted in SETUP aborts the write
      c0 = wren_cnt;
      do_write(32'h0000_1010, 32'h0000_0077, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_eq("ar_addr",   addr, 32'd0);
      check_eq("ar_data",   data, 32'd0);
      check_eq("ar_bvalid", 32'(bus.s_bvalid), 32'd0);
      check_eq("ar_wren",   32'(wren), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("ar_no_wren", 32'(wren_cnt - c0), 32'd0);
      do_write(32'h0000_1014, 32'h0000_0088, 0, 0);
      wait_idle();
      check_eq("ar_next_addr", addr, 32'h0000_0405);
      check_eq("ar_next_count", 32'(wren_cnt - c0), 32'd1);

      // back-to-back, bready tied high
      c0 = wren_cnt;
      first_hs = 0;
      for (int i = 0; i < 8; i++) begin
         do_write(32'h0000_1000 + 32'(4 * i), $urandom, 0, 0);
         if (i == 0) first_hs = hs_cyc;
      end
      check_eq("b2b_period", 32'(hs_cyc - first_hs), 32'd28);
      wait_idle();
      check_eq("b2b_count", 32'(wren_cnt - c0), 32'd8);
      check_eq("b2b_last_addr", addr, 32'h0000_0407);

`ifdef TC_GP_WR_ADDR_CHECK_EN
      c0 = wren_cnt;
      do_write(32'h0000_5000, 32'h0000_0055, 0, 0);
      @(posedge clk);
      #1;
      check_eq("ac_bad_wren",  32'(wren), 32'd0);
      check_eq("ac_bad_bresp", 32'(bus.s_bresp), 32'd2);
      wait_idle();
      do_write(32'h0000_4004, 32'h0000_0066, 0, 0);
      @(posedge clk);
      #1;
      check_eq("ac_ok_wren",  32'(wren), 32'd1);
      check_eq("ac_ok_addr",  addr, 32'h0000_1001);
      check_eq("ac_ok_bresp", 32'(bus.s_bresp), 32'd0);
      wait_idle();
      check_eq("ac_count", 32'(wren_cnt - c0), 32'd1);
`endif

      // randomized run: random addresses (incl. unaligned), gaps and bready
      bmode = 1;
      for (int i = 0; i < 40; i++) begin
         do_write(32'($urandom_range(0, 32'h7FFF)), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      bmode = 0;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
